// File: rtl/mem_read_sched.sv
// Purpose: sequences one 2-D tile-read job onto lane 0 of the skewed BRAM read fan-out.
// Latency: first rd_en one cycle after start; done R*L+N cycles after start when unstalled.
// Backpressure: stall suppresses the next issue and freezes the counters; the drain ignores stall.
module mem_read_sched #(
    parameter int N      = 4,
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_rows,
    input  logic [LEN_W-1:0]  row_len,
    input  logic [ADDR_W-1:0] row_stride,
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [LEN_W-1:0]  rows;
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] stride;
    } cfg_t;

    // Drain counter only needs to reach N-2; keep at least one bit for N<=2.
    localparam int DCW = (N > 2) ? $clog2(N - 1) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'((N > 1) ? N - 2 : 0);

    state_t            state_q, state_nxt;
    cfg_t              cfg_q, cur_cfg;
    logic [LEN_W-1:0]  r_q, c_q, eff_r, eff_c, r_nxt, c_nxt;
    logic [ADDR_W-1:0] row_start_q, eff_rs, rs_nxt, cur_addr;
    logic              all_issued_q, all_issued_nxt;
    logic [DCW-1:0]    drain_q, drain_nxt;
    logic              cfg_nonzero, row_end, cur_last, issue;
    logic              rd_en_nxt, busy_nxt, done_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_nxt;
    end

    // Address generation: in IDLE the live inputs stand in for the captured job so the
    // first element can be issued on the same edge that accepts start.
    always_comb begin
        cur_cfg     = cfg_q;
        eff_r       = r_q;
        eff_c       = c_q;
        eff_rs      = row_start_q;
        cfg_nonzero = (num_rows != '0) && (row_len != '0);
        if (state_q == S_IDLE) begin
            cur_cfg = '{rows: num_rows, len: row_len, stride: row_stride};
            eff_r   = '0;
            eff_c   = '0;
            eff_rs  = base_addr;
        end
        cur_addr = eff_rs + ADDR_W'(eff_c);
        row_end  = (eff_c == cur_cfg.len - LEN_W'(1));
        cur_last = row_end && (eff_r == cur_cfg.rows - LEN_W'(1));
        issue    = !stall && (((state_q == S_IDLE) && start && cfg_nonzero) ||
                              ((state_q == S_READ) && !all_issued_q));
        r_nxt  = eff_r;
        c_nxt  = eff_c;
        rs_nxt = eff_rs;
        if (issue) begin
            if (row_end) begin
                c_nxt  = '0;
                r_nxt  = eff_r + LEN_W'(1);
                rs_nxt = eff_rs + cur_cfg.stride;
            end else begin
                c_nxt  = eff_c + LEN_W'(1);
            end
        end
        all_issued_nxt = ((state_q == S_IDLE) ? 1'b0 : all_issued_q) | (issue && cur_last);
        drain_nxt      = (state_q == S_DRAIN) ? drain_q + DCW'(1) : '0;
    end

    // Next-state logic; READ lingers one cycle after the last issue so the final
    // registered read is visible before the drain count begins.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (start) state_nxt = cfg_nonzero ? S_READ : S_DONE;
            S_READ:  if (all_issued_q) state_nxt = (N == 1) ? S_DONE : S_DRAIN;
            S_DRAIN: if (drain_q == DRAIN_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs.
    always_comb begin
        rd_en_nxt   = issue;
        rd_addr_nxt = issue ? cur_addr : rd_addr;
        busy_nxt    = (state_nxt != S_IDLE);
        done_nxt    = (state_nxt == S_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q        <= '0;
            r_q          <= '0;
            c_q          <= '0;
            row_start_q  <= '0;
            all_issued_q <= 1'b0;
            drain_q      <= '0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && start) cfg_q <= cur_cfg;
            r_q          <= r_nxt;
            c_q          <= c_nxt;
            row_start_q  <= rs_nxt;
            all_issued_q <= all_issued_nxt;
            drain_q      <= drain_nxt;
            rd_en        <= rd_en_nxt;
            rd_addr      <= rd_addr_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

endmodule

// File: doc/mem_read_sched.md
# mem_read_sched

Read-job sequencer that drives the `rd_en`/`rd_addr` inputs of the skewed N-lane BRAM read fan-out. It accepts one 2-D tile-read job at a time (base address, row count, row length, row stride). It issues one address per cycle in row-major order and honours a downstream stall. It then waits for the N-1 cycle skew pipeline to drain and pulses `done`, so the consumer knows every lane has received its last read.

## Interface
Parameters:
- `N`, default 4: number of BRAM lanes in the skew pipeline; sets drain length to N-1 cycles.
- `ADDR_W`, default 12: BRAM address width.
- `LEN_W`, default 8: width of `num_rows` and `row_len`.

Ports:
- `clk`, input, 1: the only clock; all logic on posedge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: job request; sampled only in IDLE.
- `base_addr`, input, ADDR_W: first address of the job; captured with `start`.
- `num_rows`, input, LEN_W: rows in the job; captured with `start`.
- `row_len`, input, LEN_W: addresses per row; captured with `start`.
- `row_stride`, input, ADDR_W: address delta between row starts; captured with `start`.
- `stall`, input, 1: when high, no address is issued this cycle.
- `rd_en`, output, 1: read enable to lane 0; registered.
- `rd_addr`, output, ADDR_W: read address to lane 0; registered.
- `busy`, output, 1: job in progress; registered.
- `done`, output, 1: one-cycle pulse when the job, including drain, is complete; registered.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- **IDLE**
  - On `start`=1, capture all config, clear the row counter `r` and column counter `c`, and set the row-start pointer to `base_addr`.
  - Go to READ. If `num_rows`==0 or `row_len`==0, go to DONE instead; such a job issues no reads.
- **READ**
  - Each cycle with `stall`=0: drive `rd_en`=1 and `rd_addr` = row_start + c, then advance `c`.
  - At `c`==`row_len`-1: set `c`=0, increment `r`, and set row_start += `row_stride`.
  - After the last element (`r`==`num_rows`-1, `c`==`row_len`-1) is issued: go to DRAIN, or to DONE if N==1.
  - Cycles with `stall`=1: `rd_en`=0, `rd_addr` holds its last value, and the counters hold.
- **DRAIN**
  - Count N-1 cycles with `rd_en`=0, then go to DONE.
  - `stall` is ignored here, because the skew pipeline does not stall.
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored and is not queued.
- Address arithmetic is modulo 2^ADDR_W; additions wrap silently.
- Row-major order is fixed: address k of row r is base + r*stride + k (mod 2^ADDR_W).

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `busy`=0, `done`=0; state IDLE; counters 0.
- `rst` mid-job aborts the job: all outputs take their reset values at the next edge, and no `done` is produced.
- `start` sampled high at edge T:
  - `busy`=1 from T+1 through the DONE cycle inclusive.
  - `busy`=0 in the cycle after `done`.
- Job of R rows × L, no stall:
  - `rd_en`=1 in cycles T+1 … T+R·L.
  - DRAIN occupies T+R·L+1 … T+R·L+N-1.
  - `done` is high at T+R·L+N.
- Each stalled cycle during READ delays all later events by one cycle.
- Zero-length job: `done` is high at T+1 and `rd_en` never asserts.
- A new `start` is accepted no earlier than the cycle after `done`, because the FSM returns to IDLE on that edge. Back-to-back jobs therefore have a one-cycle gap.
- `stall` has a combinational effect on the next registered `rd_en`: `stall` high at edge E means `rd_en`=0 in cycle E+1.

## Test plan
- Basic job, N=4: base=0x010, R=2, L=3, stride=0x020, no stall.
  - `rd_addr` = 0x010, 0x011, 0x012, 0x030, 0x031, 0x032 with `rd_en`=1 in T+1..T+6.
  - `done` at T+10; `busy` high T+1..T+10.
- Wrap-around, ADDR_W=12: base=0xFFE, R=2, L=3, stride=0x004.
  - Addresses 0xFFE, 0xFFF, 0x000, 0x002, 0x003, 0x004.
- Stall: same job as basic, with `stall`=1 for the 2 cycles after the 2nd address.
  - `rd_en` shows a 2-cycle gap, addresses are unchanged in order, and `done` moves to T+12.
- Zero length: `num_rows`=0 (and separately `row_len`=0).
  - No `rd_en`; `done` at T+1; `busy` high only at T+1.
- `start` pulsed during READ and DRAIN is ignored, with no extra reads.
  - A `start` in the cycle after `done` starts a new job whose first `rd_en` appears 1 cycle later.
- Reset mid-job: assert `rst` during the 4th address.
  - Next cycle all outputs are 0; no `done`.
  - A fresh job afterwards behaves exactly as in the basic scenario.
